// File: rtl/i2s_mic_transmitter.sv
// i2s_mic_transmitter
//   I2S slave transmitter (microphone side of the link). Follows an externally
//   generated I2S_SCK/I2S_WS pair and shifts sample words out on I2S_SD.
//   Slot format: DATA_W bits MSB-first, starting one SCK after the WS change,
//   zero-padded to the end of the slot.
//
// Ports
//   clock      system clock, at least 4x the I2S_SCK frequency
//   reset      synchronous, active-high
//   I2S_SCK    bit clock from the receiver (asynchronous to clock)
//   I2S_WS     word select: 0 = left, 1 = right
//   I2S_SD     registered serial data, updated the cycle after a synced SCK fall
//   sample_l   left sample word (two's complement)
//   sample_r   right sample word
//   s_valid    sample pair valid
//   s_ready    holding register empty; pair transfers on s_valid && s_ready
//   underflow  1-cycle pulse when a left slot starts with no pending pair
//
// Build option
//   I2S_TX_REPEAT_ON_UNDERFLOW_EN  defined: retransmit the previous pair on
//   underflow; undefined: transmit silence on underflow.
//
// States
//   ST_NO_WS  | no SCK fall seen since reset; ws_last not yet meaningful
//   ST_ARMED  | ws_last valid, waiting for the first WS change (partial slot)
//   ST_LOCKED | slot-aligned; data is driven on every fall

module i2s_mic_transmitter #(
  parameter int DATA_W      = 18,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I2S_SCK,
  input  logic              I2S_WS,
  output logic              I2S_SD,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              underflow
);

  localparam int IDX_W = $clog2(SLOT_W + 1);

  typedef enum logic [1:0] {ST_NO_WS, ST_ARMED, ST_LOCKED} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sr, ws_sr;
  logic                   sck_sync, sck_sync_d, ws_now, ws_last;
  logic                   fall, boundary, locked;
  logic [DATA_W-1:0]      hold_l, hold_r, frame_l, frame_r, shreg;
  logic                   full;
  logic [IDX_W-1:0]       bit_idx;

  assign sck_sync = sck_sr[SYNC_STAGES-1];
  assign ws_now   = ws_sr[SYNC_STAGES-1];
  assign fall     = sck_sync_d & ~sck_sync;
  assign locked   = (state == ST_LOCKED);
  assign s_ready  = ~full;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sr     <= '0;
      ws_sr      <= '0;
      sck_sync_d <= 1'b0;
    end else begin
      sck_sr     <= (sck_sr << 1) | SYNC_STAGES'(I2S_SCK);
      ws_sr      <= (ws_sr << 1) | SYNC_STAGES'(I2S_WS);
      sck_sync_d <= sck_sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_NO_WS;
    else       state <= state_nxt;
  end

  // The first fall after reset only records WS, so a slot already in
  // progress at reset release is never treated as a boundary.
  always_comb begin
    state_nxt = state;
    boundary  = 1'b0;
    case (state)
      ST_NO_WS: begin
        if (fall) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (fall && (ws_now != ws_last)) begin
          state_nxt = ST_LOCKED;
          boundary  = 1'b1;
        end
      end
      ST_LOCKED: begin
        boundary = fall && (ws_now != ws_last);
      end
      default: state_nxt = ST_NO_WS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_last   <= 1'b0;
      full      <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      frame_l   <= '0;
      frame_r   <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      I2S_SD    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;

      // A consume in this cycle only happens when full, which blocks the load,
      // so the two never fight over full.
      if (s_valid && !full) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
        full   <= 1'b1;
      end

      if (fall) ws_last <= ws_now;

      if (boundary) begin
        // Last padding bit of the slot that just ended.
        I2S_SD  <= 1'b0;
        bit_idx <= '0;
        if (ws_now) begin
          shreg <= frame_r;
        end else if (full) begin
          frame_l <= hold_l;
          frame_r <= hold_r;
          shreg   <= hold_l;
          full    <= 1'b0;
        end else begin
          underflow <= 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERFLOW_EN
          shreg <= frame_l;
`else
          frame_l <= '0;
          frame_r <= '0;
          shreg   <= '0;
`endif
        end
      end else if (fall && locked) begin
        if (bit_idx < IDX_W'(DATA_W)) begin
          I2S_SD <= shreg[DATA_W-1];
          shreg  <= shreg << 1;
        end else begin
          I2S_SD <= 1'b0;
        end
        // Saturate so an over-long slot keeps padding with zeros.
        if (bit_idx != IDX_W'(SLOT_W)) bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

endmodule
